dmem_rr_arbiter: RTL and testbench

- Round-robin arbiter that time-shares the single-port data RAM among the 8 cores.
- Each core raises a read or write request; the arbiter grants one core at a time, sequences the RAM enables, and returns the result:
  - read data into a per-core holding register;
  - a one-cycle acknowledge to the granted core.
- Sits between the core array and `data_mem`, in the slot the data-memory controller occupies today.

---
 rtl/mc_pkg.sv | 15 +
 rtl/dmem_rr_arbiter_if.sv | 37 +++
 rtl/rr_pick.sv | 27 ++
 rtl/dmem_rr_arbiter.sv | 77 +++++++
 tb/tb_dmem_rr_arbiter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
// Imported by the bus interface, the picker and the arbiter top.
package mc_pkg;

    localparam int NUM_CORES_DEFAULT = 8;
    localparam int CID_W = $clog2(NUM_CORES_DEFAULT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

endpackage

// File: rtl/dmem_rr_arbiter_if.sv
// Core-array and RAM-side signal bundle of the data-memory arbiter.
// master: the arbiter; slave: cores plus data_mem.
interface dmem_rr_arbiter_if
    import mc_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NUM_CORES = NUM_CORES_DEFAULT
);
    localparam int CW = $clog2(NUM_CORES);

    logic [NUM_CORES-1:0]       req;
    logic [NUM_CORES-1:0]       we;
    logic [NUM_CORES*WIDTH-1:0] addr_in;
    logic [NUM_CORES*WIDTH-1:0] wdata_in;
    logic [WIDTH-1:0]           ram_addr;
    logic [WIDTH-1:0]           ram_wdata;
    logic                       ram_wEn;
    logic                       ram_rEn;
    logic [WIDTH-1:0]           ram_rdata;
    logic [NUM_CORES*WIDTH-1:0] rdata_out;
    logic [NUM_CORES-1:0]       ack;
    logic                       busy;
    logic [CW-1:0]              grant_id;

    modport master (
        input  req, we, addr_in, wdata_in, ram_rdata,
        output ram_addr, ram_wdata, ram_wEn, ram_rEn,
        output rdata_out, ack, busy, grant_id
    );

    modport slave (
        output req, we, addr_in, wdata_in, ram_rdata,
        input  ram_addr, ram_wdata, ram_wEn, ram_rEn,
        input  rdata_out, ack, busy, grant_id
    );

endinterface

// File: rtl/rr_pick.sv
// Rotating-priority winner select: lowest requester at or above ptr,
// wrapping past N-1 back to 0.
module rr_pick #(
    parameter int N  = 8,
    parameter int CW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] ptr,
    output logic          found,
    output logic [CW-1:0] idx
);

    logic [N-1:0]  rot;
    logic [CW-1:0] off;

    always_comb begin
        // rot[i] == req[(i + ptr) mod N]
        rot   = N'({req, req} >> ptr);
        found = |req;
        off   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = CW'(i);
        end
        idx = off + ptr;
    end

endmodule

// File: rtl/dmem_rr_arbiter.sv
// Round-robin time-sharing of the single-port data RAM among the cores.
// One transaction at a time: IDLE -> ISSUE -> (WAIT) -> ACK.
module dmem_rr_arbiter
    import mc_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NUM_CORES = NUM_CORES_DEFAULT
) (
    input logic               Clk,
    input logic               Rst,
    dmem_rr_arbiter_if.master bus
);

    localparam int CW = $clog2(NUM_CORES);

    state_t                     state;
    logic [CW-1:0]              ptr;
    logic [CW-1:0]              gid;
    logic                       l_we;
    logic [WIDTH-1:0]           l_addr;
    logic [WIDTH-1:0]           l_wdata;
    logic [NUM_CORES*WIDTH-1:0] rbank;
    logic                       pick_found;
    logic [CW-1:0]              pick_idx;

    rr_pick #(.N(NUM_CORES)) u_pick (
        .req   (bus.req),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= IDLE;
            ptr     <= '0;
            gid     <= '0;
            l_we    <= 1'b0;
            l_addr  <= '0;
            l_wdata <= '0;
            rbank   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_found) begin
                        gid     <= pick_idx;
                        l_we    <= bus.we[pick_idx];
                        l_addr  <= bus.addr_in[pick_idx*WIDTH +: WIDTH];
                        l_wdata <= bus.wdata_in[pick_idx*WIDTH +: WIDTH];
                        state   <= ISSUE;
                    end
                end
                ISSUE: state <= l_we ? ACK : WAIT;
                WAIT: begin
                    rbank[gid*WIDTH +: WIDTH] <= bus.ram_rdata;
                    state <= ACK;
                end
                ACK: begin
                    ptr   <= gid + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Address/data come straight from the latch, so they hold between ISSUEs.
    assign bus.ram_addr  = l_addr;
    assign bus.ram_wdata = l_wdata;
    assign bus.ram_wEn   = (state == ISSUE) && l_we;
    assign bus.ram_rEn   = (state == ISSUE) && !l_we;
    assign bus.ack       = (state == ACK) ? (NUM_CORES'(1) << gid) : '0;
    assign bus.busy      = (state != IDLE);
    assign bus.grant_id  = gid;
    assign bus.rdata_out = rbank;

endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// Directed plus randomized bench for dmem_rr_arbiter with a RAM model
// and a transaction-level reference (grant order, memory image, rdata bank).
module tb_dmem_rr_arbiter;
    import mc_pkg::*;

    localparam int W = 8;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_rr_arbiter_if #(.WIDTH(W), .NUM_CORES(N)) bus ();

    dmem_rr_arbiter #(.WIDTH(W), .NUM_CORES(N)) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus.master)
    );

    logic [N-1:0] req_v = '0;
    logic [N-1:0] we_v  = '0;
    logic [W-1:0] addr_v  [N];
    logic [W-1:0] wdata_v [N];

    assign bus.req = req_v;
    assign bus.we  = we_v;

    always_comb begin
        bus.addr_in  = '0;
        bus.wdata_in = '0;
        for (int i = 0; i < N; i++) begin
            bus.addr_in[i*W +: W]  = addr_v[i];
            bus.wdata_in[i*W +: W] = wdata_v[i];
        end
    end

    // data_mem stand-in: registered read, write on the enable edge
    logic [W-1:0] mem [256];
    logic [W-1:0] rdq = '0;
    assign bus.ram_rdata = rdq;
    always @(posedge clk) begin
        if (bus.ram_rEn) rdq <= mem[bus.ram_addr];
        if (bus.ram_wEn) mem[bus.ram_addr] = bus.ram_wdata;
    end

    // reference state
    logic [W-1:0] m_mem [256];
    logic [W-1:0] m_rd  [N];
    int m_ptr = 0;
    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int model_pick();
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (req_v[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [N*W-1:0] m_bank();
        logic [N*W-1:0] b;
        b = '0;
        for (int i = 0; i < N; i++) b[i*W +: W] = m_rd[i];
        return b;
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        for (int i = 0; i < N; i++) m_rd[i] = '0;
    endtask

    task automatic raise(input int c, input bit wr, input logic [W-1:0] a,
                         input logic [W-1:0] d);
        req_v[c]   = 1'b1;
        we_v[c]    = wr;
        addr_v[c]  = a;
        wdata_v[c] = d;
    endtask

    // Runs one transaction to its ack; exp_lat/exp_core < 0 skips those checks.
    task automatic serve(input int exp_lat, input int exp_core);
        int w, cyc, ren, wen, icyc;
        w = model_pick();
        if (w < 0) return;
        cyc = 0; ren = 0; wen = 0; icyc = 0;
        while (cyc < 12) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < N; i++)
                if (!req_v[i]) addr_v[i] = W'($urandom);
            if (bus.ram_rEn || bus.ram_wEn) begin
                icyc = cyc;
                chk("issue_addr", bus.ram_addr, addr_v[w]);
                if (bus.ram_wEn) chk("issue_wdata", bus.ram_wdata, wdata_v[w]);
            end
            ren += int'(bus.ram_rEn);
            wen += int'(bus.ram_wEn);
            if (bus.ack != '0) break;
        end
        chk("ack", bus.ack, N'(1) << w);
        chk("grant_id", bus.grant_id, w);
        chk("busy_in_ack", bus.busy, 1);
        if (exp_core >= 0) chk("grant_order", bus.grant_id, exp_core);
        if (exp_lat > 0) begin
            chk("ack_latency", cyc, exp_lat);
            chk("issue_cycle", icyc, 1);
        end
        if (we_v[w]) begin
            m_mem[addr_v[w]] = wdata_v[w];
            chk("wen_count", wen, 1);
            chk("ren_count", ren, 0);
        end else begin
            m_rd[w] = m_mem[addr_v[w]];
            chk("ren_count", ren, 1);
            chk("wen_count", wen, 0);
        end
        chk("rdata_out", bus.rdata_out, m_bank());
        m_ptr = (w + 1) % N;
        req_v[w] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            logic [W-1:0] v;
            v = W'($urandom);
            mem[i] = v;
            m_mem[i] = v;
        end
        mem[8'h80] = 8'h5A;
        m_mem[8'h80] = 8'h5A;
        for (int i = 0; i < N; i++) begin
            addr_v[i] = '0;
            wdata_v[i] = '0;
        end
        model_reset();

        // reset values
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ack", bus.ack, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_wen", bus.ram_wEn, 0);
        chk("rst_ren", bus.ram_rEn, 0);
        chk("rst_addr", bus.ram_addr, 0);
        chk("rst_wdata", bus.ram_wdata, 0);
        chk("rst_rdata_out", bus.rdata_out, 0);
        chk("rst_grant_id", bus.grant_id, 0);
        rst = 1'b0;
        @(negedge clk);

        // single read, core 2
        raise(2, 1'b0, 8'h80, 8'h00);
        serve(3, 2);
        chk("rd2_value", bus.rdata_out[2*W +: W], 8'h5A);

        // single write, core 5, then read back
        @(negedge clk);
        raise(5, 1'b1, 8'h90, 8'h3C);
        serve(2, 5);
        @(negedge clk);
        raise(5, 1'b0, 8'h90, 8'h00);
        serve(3, 5);
        chk("rd5_value", bus.rdata_out[5*W +: W], 8'h3C);

        // contention right after reset
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        raise(0, 1'b0, 8'h10, 8'h00);
        raise(7, 1'b0, 8'h17, 8'h00);
        serve(3, 0);
        serve(0, 7);

        // all cores held: 0..7 then 0 again
        @(negedge clk);
        for (int i = 0; i < N; i++) raise(i, 1'b0, W'(8'h20 + i), 8'h00);
        for (int k = 0; k <= N; k++) begin
            serve(0, k % N);
            if (k < N) req_v[k] = 1'b1;
        end
        while (req_v != '0) serve(0, -1);

        // wrap: last grant 6, then 0 beats 6
        @(negedge clk);
        raise(6, 1'b0, 8'h66, 8'h00);
        serve(3, 6);
        @(negedge clk);
        raise(0, 1'b0, 8'h40, 8'h00);
        raise(6, 1'b1, 8'h46, 8'hC6);
        serve(3, 0);
        serve(0, 6);

        // reset during WAIT of a read
        @(negedge clk);
        raise(1, 1'b0, 8'h22, 8'h00);
        @(negedge clk);
        chk("mid_ren", bus.ram_rEn, 1);
        @(negedge clk);
        chk("mid_wait_busy", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_ack", bus.ack, 0);
        chk("mid_busy", bus.busy, 0);
        chk("mid_rdata_out", bus.rdata_out, 0);
        rst = 1'b0;
        req_v[1] = 1'b0;
        model_reset();
        raise(3, 1'b0, 8'h80, 8'h00);
        serve(3, 3);
        chk("post_rst_rd3", bus.rdata_out[3*W +: W], 8'h5A);

        // randomized traffic against the reference
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < N; i++)
                if (!req_v[i] && $urandom_range(0, 2) == 0)
                    raise(i, 1'($urandom_range(0, 1)),
                          W'($urandom_range(0, 15)), W'($urandom));
            if (req_v == '0)
                raise($urandom_range(0, N - 1), 1'($urandom_range(0, 1)),
                      W'($urandom_range(0, 15)), W'($urandom));
            serve(0, -1);
        end
        while (req_v != '0) serve(0, -1);

        @(negedge clk);
        chk("end_idle", bus.busy, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
